// File: rtl/xor3_gate.sv
// -----------------------------------------------------------------------------
// xor3_gate
//
// Registered 3-input bitwise XOR with a zero-latency combinational copy, a
// registered parity of the captured result, and a sticky coverage map that
// records which of the eight {a,b,c} combinations have been sampled on lane 0.
//
// Parameters
//   WIDTH         number of independent XOR lanes (1..64)
//
// Ports
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   in_valid      sample enable; a/b/c captured on a rising edge when high
//   a, b, c       operands, WIDTH bits each
//   coverage_clr  synchronous clear of combo_seen (wins over a same-cycle set)
//   out           registered a^b^c
//   out_valid     high for exactly the cycle after each accepted sample
//   out_comb      combinational a^b^c, independent of clock and reset
//   parity        registered XOR-reduction of the captured result
//   combo_seen    sticky bit per lane-0 combination, index = {a[0],b[0],c[0]}
//   all_seen      high when every combo_seen bit is set
// -----------------------------------------------------------------------------
module xor3_gate #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] c,
    input  logic             coverage_clr,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_comb,
    output logic             parity,
    output logic [7:0]       combo_seen,
    output logic             all_seen
);

    // Per-lane XOR of the current operands; also feeds the capture registers
    // so the registered and combinational views can never disagree.
    logic [WIDTH-1:0] xor_now;
    logic [2:0]       combo_idx;
    logic [7:0]       combo_hit;
    logic [7:0]       combo_next;

    assign xor_now   = a ^ b ^ c;
    assign out_comb  = xor_now;
    assign combo_idx = {a[0], b[0], c[0]};

    // Next value of the coverage map. Clear outranks a simultaneous sample,
    // so the sample's bit is dropped in that cycle.
    always_comb begin
        // NOTE: every signal gets a default before any branch; otherwise a
        // path that skips the assignment infers a latch.
        combo_hit  = '0;
        combo_next = combo_seen;
        combo_hit[combo_idx] = 1'b1;
        if (coverage_clr) begin
            combo_next = '0;
        end else if (in_valid) begin
            combo_next = combo_seen | combo_hit;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out        <= '0;
            out_valid  <= 1'b0;
            parity     <= 1'b0;
            combo_seen <= '0;
        end else begin
            out_valid  <= in_valid;
            combo_seen <= combo_next;
            if (in_valid) begin
                out    <= xor_now;
                parity <= ^xor_now;
            end
        end
    end

    // Decoded straight from the registers so it rises in the same cycle the
    // final coverage bit lands.
    assign all_seen = &combo_seen;

endmodule

// File: tb/tb_xor3_gate.sv
// -----------------------------------------------------------------------------
// tb_xor3_gate
//
// Directed bench for xor3_gate: a WIDTH=1 instance exercised through the full
// truth table, coverage clear, hold and asynchronous reset, and a WIDTH=4
// instance checking lane independence and parity. Expected values are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_xor3_gate;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    // WIDTH=1 instance
    logic       in_valid1 = 1'b0;
    logic [0:0] a1 = '0, b1 = '0, c1 = '0;
    logic       clr1 = 1'b0;
    logic [0:0] out1, out_comb1;
    logic       out_valid1, parity1, all_seen1;
    logic [7:0] combo_seen1;

    // WIDTH=4 instance
    logic       in_valid4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, c4 = '0;
    logic       clr4 = 1'b0;
    logic [3:0] out4, out_comb4;
    logic       out_valid4, parity4, all_seen4;
    logic [7:0] combo_seen4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    xor3_gate #(.WIDTH(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1),
        .a(a1), .b(b1), .c(c1), .coverage_clr(clr1),
        .out(out1), .out_valid(out_valid1), .out_comb(out_comb1),
        .parity(parity1), .combo_seen(combo_seen1), .all_seen(all_seen1)
    );

    xor3_gate #(.WIDTH(4)) u4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid4),
        .a(a4), .b(b4), .c(c4), .coverage_clr(clr4),
        .out(out4), .out_valid(out_valid4), .out_comb(out_comb4),
        .parity(parity4), .combo_seen(combo_seen4), .all_seen(all_seen4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Watchdog: the sequence below is short; this only fires on a hang.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] truth;
        logic [2:0] v;
        truth = 8'b1001_0110;  // truth[{a,b,c}] = a^b^c

        // ---- reset state (no clock edge yet) ----
        #2;
        check("rst_out",        64'(out1), 64'h0);
        check("rst_out_valid",  64'(out_valid1), 64'h0);
        check("rst_parity",     64'(parity1), 64'h0);
        check("rst_combo_seen", 64'(combo_seen1), 64'h00);
        check("rst_all_seen",   64'(all_seen1), 64'h0);
        check("rst_out4",       64'(out4), 64'h0);

        // Release between edges, away from the rising edge at t=15.
        #10 rst_n = 1'b1;

        // ---- WIDTH=1 sweep over all eight combinations ----
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            {a1, b1, c1} = v;
            in_valid1 = 1'b1;
            #1;
            check($sformatf("sweep_comb_%0d", i), 64'(out_comb1), 64'(truth[v]));
            tick();
            check($sformatf("sweep_out_%0d", i),    64'(out1), 64'(truth[v]));
            check($sformatf("sweep_par_%0d", i),    64'(parity1), 64'(truth[v]));
            check($sformatf("sweep_valid_%0d", i),  64'(out_valid1), 64'h1);
        end
        check("sweep_combo_seen", 64'(combo_seen1), 64'hFF);
        check("sweep_all_seen",   64'(all_seen1), 64'h1);

        // ---- clear with a simultaneous sample of 111: clear wins ----
        {a1, b1, c1} = 3'b111;
        clr1 = 1'b1;
        tick();
        check("clr_combo_seen", 64'(combo_seen1), 64'h00);
        check("clr_all_seen",   64'(all_seen1), 64'h0);
        check("clr_out",        64'(out1), 64'h1);
        check("clr_valid",      64'(out_valid1), 64'h1);
        clr1 = 1'b0;

        // ---- hold ----
        {a1, b1, c1} = 3'b011;
        tick();
        check("hold_out_011",  64'(out1), 64'h0);
        check("hold_cov_011",  64'(combo_seen1), 64'h08);
        {a1, b1, c1} = 3'b001;
        tick();
        check("hold_out_001",  64'(out1), 64'h1);
        check("hold_cov_001",  64'(combo_seen1), 64'h0A);
        in_valid1 = 1'b0;
        {a1, b1, c1} = 3'b111;
        tick();
        check("hold_out",      64'(out1), 64'h1);
        check("hold_parity",   64'(parity1), 64'h1);
        check("hold_valid",    64'(out_valid1), 64'h0);
        check("hold_comb",     64'(out_comb1), 64'h1);
        check("hold_cov_bit7", 64'(combo_seen1[7]), 64'h0);
        check("hold_cov",      64'(combo_seen1), 64'h0A);

        // ---- asynchronous reset mid-run ----
        {a1, b1, c1} = 3'b001;
        in_valid1 = 1'b1;
        tick();
        check("pre_rst_out",   64'(out1), 64'h1);
        check("pre_rst_valid", 64'(out_valid1), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_out",        64'(out1), 64'h0);
        check("arst_parity",     64'(parity1), 64'h0);
        check("arst_valid",      64'(out_valid1), 64'h0);
        check("arst_combo_seen", 64'(combo_seen1), 64'h00);
        check("arst_comb",       64'(out_comb1), 64'h1);
        // Registers stay cleared across an edge while reset is held.
        tick();
        check("arst_hold_out",   64'(out1), 64'h0);
        check("arst_hold_valid", 64'(out_valid1), 64'h0);
        #3 rst_n = 1'b1;
        {a1, b1, c1} = 3'b100;
        tick();
        check("post_rst_out",   64'(out1), 64'h1);
        check("post_rst_valid", 64'(out_valid1), 64'h1);
        check("post_rst_cov",   64'(combo_seen1), 64'h10);
        in_valid1 = 1'b0;

        // ---- WIDTH=4 lane independence and parity ----
        a4 = 4'b1100; b4 = 4'b1010; c4 = 4'b0110;
        in_valid4 = 1'b1;
        #1;
        check("w4_comb_1",   64'(out_comb4), 64'h0);
        tick();
        check("w4_out_1",    64'(out4), 64'h0);
        check("w4_parity_1", 64'(parity4), 64'h0);
        check("w4_valid_1",  64'(out_valid4), 64'h1);
        a4 = 4'b1000; b4 = 4'b0000; c4 = 4'b0000;
        #1;
        check("w4_comb_2",   64'(out_comb4), 64'h8);
        tick();
        check("w4_out_2",    64'(out4), 64'h8);
        check("w4_parity_2", 64'(parity4), 64'h1);
        check("w4_cov",      64'(combo_seen4), 64'h01);
        a4 = 4'b0111; b4 = 4'b0001; c4 = 4'b0000;
        in_valid4 = 1'b0;
        tick();
        check("w4_hold_out",   64'(out4), 64'h8);
        check("w4_hold_valid", 64'(out_valid4), 64'h0);
        check("w4_hold_comb",  64'(out_comb4), 64'h6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xor3_gate.md
Name: xor3_gate

Overview:
- Registered 3-input bitwise XOR: `out = a ^ b ^ c`, one lane per bit of WIDTH.
- Also provides a combinational copy of the result, a registered parity of the result, and a sticky coverage map of which of the 8 input combinations on lane 0 have been sampled.
- Used as a leaf logic-gate primitive and as a self-checking target for exhaustive truth-table benches.

Parameters:
- WIDTH, default 1: number of independent XOR lanes (width of a, b, c, out, out_comb); legal range 1..64.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  sample enable; inputs are captured on a rising clk edge only when high.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- c  input  WIDTH  operand C.
- coverage_clr  input  1  synchronous clear of the coverage map.
- out  output  WIDTH  registered a^b^c.
- out_valid  output  1  high for exactly the cycle after each accepted sample.
- out_comb  output  WIDTH  combinational a^b^c; no clock or reset dependence.
- parity  output  1  registered XOR-reduction of the captured result.
- combo_seen  output  8  sticky bit per lane-0 input combination; index = {a[0],b[0],c[0]}.
- all_seen  output  1  combinational AND of combo_seen.

Behaviour:
- Reset (rst_n low) takes effect immediately, with no clock required:
  - out = 0, out_valid = 0, parity = 0, combo_seen = 0.
  - out_comb is unaffected by reset.
  - Registers stay cleared while rst_n is low.
  - Normal operation begins at the first rising edge after rst_n goes high.
- Truth table per lane: 000→0, 001→1, 010→1, 011→0, 100→1, 101→0, 110→0, 111→1 (odd count of ones → 1).
- out_comb:
  - Pure combinational function of the current a, b, c.
  - Zero latency; ignores in_valid.
- Rising edge with in_valid = 1:
  - out ← a^b^c.
  - parity ← ^(a^b^c).
  - out_valid ← 1.
  - combo_seen[{a[0],b[0],c[0]}] ← 1.
  - Latency is 1 cycle; back-to-back samples are accepted every cycle.
- Rising edge with in_valid = 0:
  - out and parity hold their previous values.
  - out_valid ← 0.
  - combo_seen unchanged.
- coverage_clr = 1 at a rising edge:
  - combo_seen ← 0.
  - Clear has priority over a set from a simultaneous in_valid sample; that sample's coverage bit is discarded.
  - out, parity and out_valid still update normally.
- Coverage bits are sticky: once set, a bit stays 1 until coverage_clr or reset. Repeated combinations have no further effect.
- all_seen = 1 if and only if all 8 combo_seen bits are 1. It is combinational from the registers, so it asserts in the same cycle the last bit sets.
- For WIDTH > 1, lanes are fully independent; only lane 0 feeds coverage.
- No X-propagation handling is required; inputs are assumed driven whenever in_valid = 1.

Test Plan:
- WIDTH=1 sweep: apply the eight {a,b,c} vectors 000..111 with in_valid=1, one per cycle → out follows 0,1,1,0,1,0,0,1 one cycle later; out_comb matches in the same cycle; out_valid stays 1 throughout.
- Coverage after the sweep → combo_seen = 8'hFF and all_seen = 1. Then pulse coverage_clr together with in_valid and abc=111 → combo_seen = 0 and out = 1.
- Hold: sample abc=011 (out=0), then abc=001 (out=1), then drop in_valid and change abc to 111 → out stays 1, out_valid = 0, out_comb = 1, combo_seen bit 7 remains 0.
- Async reset mid-sweep: assert rst_n=0 between clock edges while out=1 → out, parity, out_valid and combo_seen go to 0 immediately. After release, the next sample of abc=100 → out = 1.
- WIDTH=4: a=4'b1100, b=4'b1010, c=4'b0110 → out_comb = 4'b0000 immediately; next cycle out = 4'b0000 and parity = 0. Then a=4'b1000, b=0, c=0 → out = 4'b1000 and parity = 1.
